// File: rtl/canny_pkg.sv
// Shared definitions for the Canny front end: pixel width, 3x3 window tap layout and tap extraction.
package canny_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned WIN_TAPS           = 9;

  // Tap k sits at window row k/3, column k%3; TL is the LSB slice.
  localparam int unsigned WIN_TL = 0;
  localparam int unsigned WIN_TC = 1;
  localparam int unsigned WIN_TR = 2;
  localparam int unsigned WIN_ML = 3;
  localparam int unsigned WIN_MC = 4;
  localparam int unsigned WIN_MR = 5;
  localparam int unsigned WIN_BL = 6;
  localparam int unsigned WIN_BC = 7;
  localparam int unsigned WIN_BR = 8;

  function automatic logic [DEFAULT_DATA_WIDTH-1:0] win_tap(
    input logic [WIN_TAPS*DEFAULT_DATA_WIDTH-1:0] win,
    input int unsigned                            k
  );
    return win[k*DEFAULT_DATA_WIDTH +: DEFAULT_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out stream bundle for window_3x3_gen.
// frame_done exists only when WIN_FRAME_DONE_EN is defined.
interface window_3x3_gen_if
  import canny_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256
);
  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  logic                           in_valid;
  logic                           in_sof;
  logic [DATA_WIDTH-1:0]          in_data;
  logic                           out_valid;
  logic [WIN_TAPS*DATA_WIDTH-1:0] out_win;
  logic [RW-1:0]                  out_row;
  logic [CW-1:0]                  out_col;
`ifdef WIN_FRAME_DONE_EN
  logic                           frame_done;

  modport master (output in_valid, in_sof, in_data,
                  input  out_valid, out_win, out_row, out_col, frame_done);
  modport slave  (input  in_valid, in_sof, in_data,
                  output out_valid, out_win, out_row, out_col, frame_done);
`else
  modport master (output in_valid, in_sof, in_data,
                  input  out_valid, out_win, out_row, out_col);
  modport slave  (input  in_valid, in_sof, in_data,
                  output out_valid, out_win, out_row, out_col);
`endif

endinterface

// File: rtl/window_line_buffer.sv
// One image row of pixel storage: combinational read, synchronous write to the same address.
// Contents are deliberately not reset; every location is rewritten before it can reach a window.
module window_line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic [DATA_WIDTH-1:0] rdData_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wrData;
  end

  // Read returns the old word in the cycle it is overwritten.
  assign rdData_c = mem[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window, one pixel per cycle.
// Optional WIN_FRAME_DONE_EN adds a frame_done pulse on the last interior window of a frame.
module window_3x3_gen
  import canny_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256
) (
  input  logic              clk,
  input  logic              reset,
  window_3x3_gen_if.slave   bus
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] colCnt, col;
  logic [RW-1:0] rowCnt, row;
  logic          lastCol, lastRow;
  logic [DATA_WIDTH-1:0] lb0Rd, lb1Rd;
  logic [WIN_TAPS-1:0][DATA_WIDTH-1:0] winReg, winNext;

  // Start-of-frame forces the pixel to (0,0) regardless of where the counters are.
  assign col     = bus.in_sof ? '0 : colCnt;
  assign row     = bus.in_sof ? '0 : rowCnt;
  assign lastCol = (col == CW'(IMG_WIDTH - 1));
  assign lastRow = (row == RW'(IMG_HEIGHT - 1));

  window_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(CW)) lb0 (
    .clk(clk), .we(bus.in_valid), .addr(col), .wrData(bus.in_data), .rdData_c(lb0Rd)
  );

  window_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(CW)) lb1 (
    .clk(clk), .we(bus.in_valid), .addr(col), .wrData(lb0Rd), .rdData_c(lb1Rd)
  );

  // Post-shift window: columns move left, new right column is {lb1, lb0, in_data} top to bottom.
  always_comb begin
    winNext         = winReg;
    winNext[WIN_TL] = winReg[WIN_TC];
    winNext[WIN_TC] = winReg[WIN_TR];
    winNext[WIN_ML] = winReg[WIN_MC];
    winNext[WIN_MC] = winReg[WIN_MR];
    winNext[WIN_BL] = winReg[WIN_BC];
    winNext[WIN_BC] = winReg[WIN_BR];
    winNext[WIN_TR] = lb1Rd;
    winNext[WIN_MR] = lb0Rd;
    winNext[WIN_BR] = bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      colCnt <= '0;
      rowCnt <= '0;
      winReg <= '0;
    end else if (bus.in_valid) begin
      winReg <= winNext;
      if (lastCol) begin
        colCnt <= '0;
        rowCnt <= lastRow ? '0 : row + RW'(1);
      end else begin
        colCnt <= col + CW'(1);
        rowCnt <= row;
      end
    end
  end

  // Only interior centres are emitted; the col gate also hides stale columns after a row wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_win   <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
    end else begin
      bus.out_valid <= bus.in_valid && (row >= RW'(2)) && (col >= CW'(2));
      if (bus.in_valid) begin
        bus.out_win <= winNext;
        bus.out_row <= row - RW'(1);
        bus.out_col <= col - CW'(1);
      end
    end
  end

`ifdef WIN_FRAME_DONE_EN
  // The bottom-right pixel is only reachable by a frame that ran to completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.frame_done <= 1'b0;
    else       bus.frame_done <= bus.in_valid && lastRow && lastCol;
  end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on an 8x6 image; model keeps the whole frame in a 2D array.
// Build with WIN_FRAME_DONE_EN defined to also check frame_done.
module tb_window_3x3_gen;
  import canny_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned CW = 3;
  localparam int unsigned RW = 3;

  typedef struct packed {
    logic                   fd;
    logic [RW-1:0]          row;
    logic [CW-1:0]          col;
    logic [WIN_TAPS*DW-1:0] win;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  window_3x3_gen_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) busIf ();

  window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .bus(busIf)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  int    fdCount     = 0;
  beat_t expQ[$];
  beat_t seen[$];
  logic [DW-1:0] img [H][W];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a window is the 3x3 block of the stored image ending at the pixel just accepted.
  function automatic void modelAccept(input int r, input int c, input logic [DW-1:0] d);
    beat_t e;
    img[r][c] = d;
    if (r >= 2 && c >= 2) begin
      e     = '0;
      e.row = RW'(r - 1);
      e.col = CW'(c - 1);
      for (int k = 0; k < 9; k++) e.win[k*DW +: DW] = img[r-2+k/3][c-2+k%3];
`ifdef WIN_FRAME_DONE_EN
      e.fd = (r == int'(H) - 1) && (c == int'(W) - 1);
`endif
      expQ.push_back(e);
    end
  endfunction

  task automatic sendPixel(input logic sof, input logic [DW-1:0] d);
    busIf.in_valid = 1'b1;
    busIf.in_sof   = sof;
    busIf.in_data  = d;
    @(posedge clk); #1;
    busIf.in_valid = 1'b0;
    busIf.in_sof   = 1'b0;
  endtask

  // Stall cycles also toggle in_sof/in_data to show they are ignored without in_valid.
  task automatic idle(input int n);
    repeat (n) begin
      busIf.in_valid = 1'b0;
      busIf.in_sof   = 1'($urandom);
      busIf.in_data  = DW'($urandom);
      @(posedge clk); #1;
    end
    busIf.in_sof = 1'b0;
  endtask

  task automatic sendFrame(input int base, input bit rnd, input bit gaps, input bit sofFirst, input int nPix);
    int r;
    int c;
    logic [DW-1:0] d;
    for (int i = 0; i < nPix; i++) begin
      r = i / int'(W);
      c = i % int'(W);
      if (gaps && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      d = rnd ? DW'($urandom) : DW'(base + r*16 + c);
      sendPixel(sofFirst && i == 0, d);
      modelAccept(r, c, d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", 128'(expQ.size()), 128'(0));
    expQ.delete();
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "_valid"}, 128'(busIf.out_valid), 128'(0));
    check({tag, "_win"},   128'(busIf.out_win),   128'(0));
    check({tag, "_row"},   128'(busIf.out_row),   128'(0));
    check({tag, "_col"},   128'(busIf.out_col),   128'(0));
`ifdef WIN_FRAME_DONE_EN
    check({tag, "_fd"},    128'(busIf.frame_done), 128'(0));
`endif
  endtask

  // Monitor: every presented beat is logged and compared with the head of the expected queue.
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    if (!reset && busIf.out_valid) begin
      got     = '0;
      got.win = busIf.out_win;
      got.row = busIf.out_row;
      got.col = busIf.out_col;
`ifdef WIN_FRAME_DONE_EN
      got.fd  = busIf.frame_done;
      if (busIf.frame_done) fdCount++;
`endif
      seen.push_back(got);
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got row=%0d col=%0d win=%0h, none expected", got.row, got.col, got.win);
      end else begin
        e = expQ.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL window_beat: got fd=%0d row=%0d col=%0d win=%0h expected fd=%0d row=%0d col=%0d win=%0h",
                   got.fd, got.row, got.col, got.win, e.fd, e.row, e.col, e.win);
        end
      end
    end
`ifdef WIN_FRAME_DONE_EN
    if (!reset && busIf.frame_done && !busIf.out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_done_alone: got frame_done=1 expected out_valid=1 with it");
    end
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int fdBase;
    busIf.in_valid = 1'b0;
    busIf.in_sof   = 1'b0;
    busIf.in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutputsZero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // Gap-free counting-pattern frame with directed spot checks.
    seen.delete();
    sendFrame(0, 1'b0, 1'b0, 1'b1, int'(W*H));
    idle(3);
    drain();
    check("frame1_count", 128'(seen.size()), 128'(24));
    if (seen.size() == 24) begin
      check("first_win", 128'(seen[0].win), 128'(72'h22_21_20_12_11_10_02_01_00));
      check("first_row", 128'(seen[0].row), 128'(1));
      check("first_col", 128'(seen[0].col), 128'(1));
      check("last_row",  128'(seen[23].row), 128'(4));
      check("last_col",  128'(seen[23].col), 128'(6));
      check("last_br",   128'(win_tap(seen[23].win, WIN_BR)), 128'(8'h57));
      idx = -1;
      foreach (seen[i]) if (seen[i].row == 2 && seen[i].col == 1) idx = i;
      check("rowwrap_2_1_found", 128'(idx >= 0), 128'(1));
      if (idx >= 0) check("rowwrap_2_1_win", 128'(seen[idx].win), 128'(72'h32_31_30_22_21_20_12_11_10));
    end

    // Same pattern with random stalls; stray valids show up as unexpected beats.
    seen.delete();
    sendFrame(0, 1'b0, 1'b1, 1'b1, int'(W*H));
    idle(3);
    drain();
    check("gap_frame_count", 128'(seen.size()), 128'(24));

    // Random pixel data with gaps over several frames.
    for (int f = 0; f < 3; f++) sendFrame(0, 1'b1, 1'b1, 1'b1, int'(W*H));
    idle(3);
    drain();

    // in_sof at (3,4) of frame A restarts into frame B (offset pattern keeps frames distinct).
    sendFrame(0, 1'b0, 1'b0, 1'b1, int'(3*W + 4));
    idle(1);
    drain();
    seen.delete();
    sendFrame(8'h80, 1'b0, 1'b0, 1'b1, int'(W*H));
    idle(3);
    drain();
    check("sof_frame_count", 128'(seen.size()), 128'(24));
    if (seen.size() != 0) begin
      check("sof_first_row", 128'(seen[0].row), 128'(1));
      check("sof_first_col", 128'(seen[0].col), 128'(1));
      check("sof_first_win", 128'(seen[0].win), 128'(72'hA2_A1_A0_92_91_90_82_81_80));
    end

    // Reset mid-row 3; the following frame carries no in_sof and must still start at (0,0).
    sendFrame(0, 1'b1, 1'b0, 1'b1, int'(3*W + 4));
    idle(1);
    drain();
    reset = 1'b1;
    @(negedge clk);
    checkOutputsZero("in_reset_a");
    @(negedge clk);
    checkOutputsZero("in_reset_b");
    @(posedge clk); #1;
    reset = 1'b0;
    seen.delete();
    sendFrame(0, 1'b0, 1'b0, 1'b0, int'(W*H));
    idle(3);
    drain();
    check("post_reset_count", 128'(seen.size()), 128'(24));
    if (seen.size() == 24) check("post_reset_first_win", 128'(seen[0].win), 128'(72'h22_21_20_12_11_10_02_01_00));

    // Two back-to-back frames for the frame_done count.
    fdBase = fdCount;
    sendFrame(0, 1'b1, 1'b0, 1'b1, int'(W*H));
    sendFrame(0, 1'b1, 1'b0, 1'b1, int'(W*H));
    idle(3);
    drain();
`ifdef WIN_FRAME_DONE_EN
    check("frame_done_pulses", 128'(fdCount - fdBase), 128'(2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
